// File: rtl/uart_pkg.sv
// Shared UART constants: byte width and byte-order selectors.
package uart_pkg;

    localparam int unsigned UART_BYTE_W = 8;

    localparam bit UART_LITTLE_ENDIAN = 1'b0;
    localparam bit UART_BIG_ENDIAN    = 1'b1;

endpackage : uart_pkg

// File: rtl/uart_word_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry an extra wrap bit
// so full and empty are distinguished without a separate counter.
module uart_word_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    input  logic                           flush,
    output logic [WIDTH-1:0]               head_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Status flags and head word; a full FIFO still accepts a push when it pops.
    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        level     = wr_ptr_q - rd_ptr_q;
        head_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
        do_pop    = pop && !empty && !flush;
        do_push   = push && (!full || do_pop) && !flush;
    end

    // Pointer next-state, flush returns both pointers to zero.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are masked by empty so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule : uart_word_fifo

// File: rtl/uart_word_assembler.sv
// Packs received UART bytes into words, drops stale partial words after an
// idle timeout, and queues finished words for a valid/ready consumer.
module uart_word_assembler
    import uart_pkg::*;
#(
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter bit          BIG_ENDIAN     = UART_LITTLE_ENDIAN,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned OUT_DEPTH      = 4,
    localparam int unsigned WORD_W        = UART_BYTE_W * BYTES_PER_WORD,
    localparam int unsigned CNT_W         = $clog2(BYTES_PER_WORD),
    localparam int unsigned LVL_W         = $clog2(OUT_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   rx_done,
    input  logic [UART_BYTE_W-1:0] rx_byte,
    input  logic                   flush,
    input  logic                   clear_ovf,
    output logic [WORD_W-1:0]      word_data,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic [CNT_W-1:0]       byte_count,
    output logic [LVL_W-1:0]       fifo_level,
    output logic                   overflow,
    output logic                   frame_err
);

    localparam int unsigned IDLE_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES_PER_WORD - 1);

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [WORD_W-1:0] part_q;
    logic [WORD_W-1:0] part_d;
    logic [IDLE_W-1:0] idle_q;
    logic [IDLE_W-1:0] idle_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              ferr_q;
    logic              ferr_d;

    logic [WORD_W-1:0] merged_c;
    logic              push_c;
    logic              pop_c;
    logic              fifo_full;
    logic              fifo_empty;

    // Partial word with the incoming byte placed in its lane for this position.
    always_comb begin
        merged_c = part_q;
        for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                if (BIG_ENDIAN == UART_BIG_ENDIAN) begin
                    merged_c[WORD_W - UART_BYTE_W*(k+1) +: UART_BYTE_W] = rx_byte;
                end else begin
                    merged_c[UART_BYTE_W*k +: UART_BYTE_W] = rx_byte;
                end
            end
        end
    end

    assign pop_c = word_valid && word_ready;

    // Packer, idle timeout and sticky overflow next-state; flush overrides all.
    always_comb begin
        cnt_d  = cnt_q;
        part_d = part_q;
        idle_d = idle_q;
        ovf_d  = ovf_q;
        ferr_d = 1'b0;
        push_c = 1'b0;
        if (flush) begin
            cnt_d  = '0;
            part_d = '0;
            idle_d = '0;
            ovf_d  = 1'b0;
        end else begin
            if (rx_done) begin
                idle_d = '0;
                if (cnt_q == LAST_CNT) begin
                    push_c = 1'b1;
                    cnt_d  = '0;
                    part_d = '0;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    part_d = merged_c;
                end
            end else if ((cnt_q != '0) && (TIMEOUT_CYCLES != 0)) begin
                if (32'(idle_q) + 32'd1 == TIMEOUT_CYCLES) begin
                    cnt_d  = '0;
                    part_d = '0;
                    idle_d = '0;
                    ferr_d = 1'b1;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end else begin
                idle_d = '0;
            end

            if (push_c && fifo_full && !pop_c) begin
                ovf_d = 1'b1;
            end else if (clear_ovf) begin
                ovf_d = 1'b0;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            part_q <= '0;
            idle_q <= '0;
            ovf_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            part_q <= part_d;
            idle_q <= idle_d;
            ovf_q  <= ovf_d;
            ferr_q <= ferr_d;
        end
    end

    uart_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_c),
        .push_data (merged_c),
        .pop       (pop_c),
        .flush     (flush),
        .head_data (word_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign word_valid = !fifo_empty;
    assign byte_count = cnt_q;
    assign overflow   = ovf_q;
    assign frame_err  = ferr_q;

endmodule : uart_word_assembler

// File: tb/tb_uart_word_assembler.sv
// Bench for uart_word_assembler: little-endian/timeout, big-endian and
// two-byte variants share stimulus; the first is also checked randomly.
module tb_uart_word_assembler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx_done;
    logic [7:0] rx_byte;
    logic       flush;
    logic       clear_ovf;
    logic       word_ready;

    logic [31:0] a_data;  logic a_valid; logic [1:0] a_cnt; logic [2:0] a_lvl; logic a_ovf; logic a_ferr;
    logic [31:0] b_data;  logic b_valid; logic [1:0] b_cnt; logic [2:0] b_lvl; logic b_ovf; logic b_ferr;
    logic [15:0] c_data;  logic c_valid; logic [0:0] c_cnt; logic [2:0] c_lvl; logic c_ovf; logic c_ferr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_word_assembler #(.BYTES_PER_WORD(4), .BIG_ENDIAN(1'b0), .TIMEOUT_CYCLES(10), .OUT_DEPTH(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .rx_done(rx_done), .rx_byte(rx_byte), .flush(flush),
        .clear_ovf(clear_ovf), .word_data(a_data), .word_valid(a_valid), .word_ready(word_ready),
        .byte_count(a_cnt), .fifo_level(a_lvl), .overflow(a_ovf), .frame_err(a_ferr));

    uart_word_assembler #(.BYTES_PER_WORD(4), .BIG_ENDIAN(1'b1), .TIMEOUT_CYCLES(0), .OUT_DEPTH(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .rx_done(rx_done), .rx_byte(rx_byte), .flush(flush),
        .clear_ovf(clear_ovf), .word_data(b_data), .word_valid(b_valid), .word_ready(word_ready),
        .byte_count(b_cnt), .fifo_level(b_lvl), .overflow(b_ovf), .frame_err(b_ferr));

    uart_word_assembler #(.BYTES_PER_WORD(2), .BIG_ENDIAN(1'b1), .TIMEOUT_CYCLES(0), .OUT_DEPTH(4)) dut_c (
        .clk(clk), .reset_n(reset_n), .rx_done(rx_done), .rx_byte(rx_byte), .flush(flush),
        .clear_ovf(clear_ovf), .word_data(c_data), .word_valid(c_valid), .word_ready(word_ready),
        .byte_count(c_cnt), .fifo_level(c_lvl), .overflow(c_ovf), .frame_err(c_ferr));

    typedef struct {
        logic [3:0][7:0] b;
        logic [31:0]     exp_le;
        logic [31:0]     exp_be;
        logic [15:0]     exp_c0;
        logic [15:0]     exp_c1;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One byte strobe captured at the next rising edge; returns at a falling edge.
    task automatic send_byte(input logic [7:0] b);
        rx_done = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    function automatic logic [7:0] pat(input int w, input int j);
        return 8'((w * 16 + j + 'h50) & 'hff);
    endfunction

    function automatic logic [31:0] pat_word(input int w);
        return {pat(w, 3), pat(w, 2), pat(w, 1), pat(w, 0)};
    endfunction

    // Reference model for dut_a: byte queue, word queue, plain counters.
    logic [31:0] mq [$];
    logic [7:0]  part [$];
    int          m_idle;
    bit          m_ovf;
    bit          m_ferr;

    initial begin
        logic [31:0] exp_w [5];
        bit          ferr_seen;
        int          mode;

        vecs[0] = '{b: {8'h44, 8'h33, 8'h22, 8'h11}, exp_le: 32'h44332211, exp_be: 32'h11223344, exp_c0: 16'h1122, exp_c1: 16'h3344};
        vecs[1] = '{b: {8'h01, 8'hEF, 8'hCD, 8'hAB}, exp_le: 32'h01EFCDAB, exp_be: 32'hABCDEF01, exp_c0: 16'hABCD, exp_c1: 16'hEF01};
        vecs[2] = '{b: {8'hFF, 8'h00, 8'hFF, 8'h00}, exp_le: 32'hFF00FF00, exp_be: 32'h00FF00FF, exp_c0: 16'h00FF, exp_c1: 16'h00FF};
        vecs[3] = '{b: {8'hEF, 8'hBE, 8'hAD, 8'hDE}, exp_le: 32'hEFBEADDE, exp_be: 32'hDEADBEEF, exp_c0: 16'hDEAD, exp_c1: 16'hBEEF};

        reset_n = 1'b0; rx_done = 1'b0; rx_byte = 8'h00; flush = 1'b0; clear_ovf = 1'b0; word_ready = 1'b0;
        #7;
        chk("reset_valid", 32'(a_valid), 0);
        chk("reset_data",  a_data, 0);
        chk("reset_cnt",   32'(a_cnt), 0);
        chk("reset_lvl",   32'(a_lvl), 0);
        chk("reset_ovf_ferr", {30'd0, a_ovf, a_ferr}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Table: byte order and one-cycle visibility with consumer ready.
        word_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_done = 1'b1;
            rx_byte = vecs[i].b[0];
            @(negedge clk);
            rx_byte = vecs[i].b[1];
            @(negedge clk);
            chk("c_valid0", 32'(c_valid), 1);
            chk("c_word0",  32'(c_data), 32'(vecs[i].exp_c0));
            rx_byte = vecs[i].b[2];
            @(negedge clk);
            rx_byte = vecs[i].b[3];
            @(negedge clk);
            rx_done = 1'b0;
            chk("le_valid", 32'(a_valid), 1);
            chk("le_word",  a_data, vecs[i].exp_le);
            chk("le_level", 32'(a_lvl), 1);
            chk("be_word",  b_data, vecs[i].exp_be);
            chk("c_word1",  32'(c_data), 32'(vecs[i].exp_c1));
            @(negedge clk);
            chk("le_valid_after_pop", 32'(a_valid), 0);
        end

        // Five words into a depth-4 FIFO with the consumer stalled.
        word_ready = 1'b0;
        for (int w = 0; w < 5; w++) begin
            exp_w[w] = pat_word(w);
            for (int j = 0; j < 4; j++) send_byte(pat(w, j));
        end
        chk("ovf_level", 32'(a_lvl), 4);
        chk("ovf_flag",  32'(a_ovf), 1);
        for (int w = 0; w < 4; w++) begin
            chk("ovf_drain_word", a_data, exp_w[w]);
            word_ready = 1'b1;
            @(negedge clk);
        end
        word_ready = 1'b0;
        chk("ovf_drained_valid", 32'(a_valid), 0);
        chk("ovf_sticky", 32'(a_ovf), 1);
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        chk("ovf_cleared", 32'(a_ovf), 0);

        // Full FIFO with push and pop together: no drop.
        for (int w = 0; w < 4; w++)
            for (int j = 0; j < 4; j++) send_byte(pat(w + 6, j));
        for (int j = 0; j < 3; j++) send_byte(pat(10, j));
        word_ready = 1'b1;
        send_byte(pat(10, 3));
        word_ready = 1'b0;
        chk("pp_level", 32'(a_lvl), 4);
        chk("pp_no_ovf", 32'(a_ovf), 0);
        for (int w = 7; w <= 10; w++) begin
            chk("pp_drain_word", a_data, pat_word(w));
            word_ready = 1'b1;
            @(negedge clk);
        end
        chk("pp_drained", 32'(a_valid), 0);

        // Timeout: two bytes then idle clocks.
        send_byte(8'h11);
        send_byte(8'h22);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 9) begin
                chk("to_cnt_before", 32'(a_cnt), 2);
                chk("to_ferr_before", 32'(a_ferr), 0);
            end
            if (k == 10) begin
                chk("to_ferr_pulse", 32'(a_ferr), 1);
                chk("to_cnt_zero", 32'(a_cnt), 0);
            end
            if (k == 11) chk("to_ferr_one_cycle", 32'(a_ferr), 0);
        end
        for (int j = 0; j < 4; j++) send_byte(8'(8'hA0 + j));
        chk("to_next_word", a_data, 32'hA3A2A1A0);
        @(negedge clk);

        // Byte arriving on the tenth idle clock continues the word.
        ferr_seen = 1'b0;
        send_byte(8'h01);
        send_byte(8'h02);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            ferr_seen |= a_ferr;
        end
        send_byte(8'h03);
        ferr_seen |= a_ferr;
        send_byte(8'h04);
        ferr_seen |= a_ferr;
        chk("edge_no_ferr", 32'(ferr_seen), 0);
        chk("edge_word", a_data, 32'h04030201);
        @(negedge clk);

        // Flush with queued words, a partial word and a byte in the same cycle.
        word_ready = 1'b0;
        for (int w = 0; w < 2; w++)
            for (int j = 0; j < 4; j++) send_byte(pat(w, j));
        for (int j = 0; j < 3; j++) send_byte(8'h90);
        chk("fl_pre_level", 32'(a_lvl), 2);
        chk("fl_pre_cnt", 32'(a_cnt), 3);
        flush = 1'b1; rx_done = 1'b1; rx_byte = 8'h77;
        @(negedge clk);
        flush = 1'b0; rx_done = 1'b0;
        chk("fl_level", 32'(a_lvl), 0);
        chk("fl_cnt", 32'(a_cnt), 0);
        chk("fl_valid", 32'(a_valid), 0);
        chk("fl_ovf", 32'(a_ovf), 0);
        for (int j = 0; j < 4; j++) send_byte(8'(8'h61 + j));
        chk("fl_next_word", a_data, 32'h64636261);

        // Flush also clears a set overflow.
        for (int w = 0; w < 5; w++)
            for (int j = 0; j < 4; j++) send_byte(pat(w, j));
        chk("fl2_ovf_set", 32'(a_ovf), 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl2_ovf_clr", 32'(a_ovf), 0);

        // Asynchronous reset mid-word with words queued.
        for (int j = 0; j < 6; j++) send_byte(pat(3, j));
        chk("rst_pre_level", 32'(a_lvl), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_valid", 32'(a_valid), 0);
        chk("rst_data", a_data, 0);
        chk("rst_cnt", 32'(a_cnt), 0);
        chk("rst_lvl", 32'(a_lvl), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized traffic on dut_a against the queue model.
        mq.delete(); part.delete(); m_idle = 0; m_ovf = 1'b0; m_ferr = 1'b0;
        mode = 0;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            bit full, pop, done, drop;
            logic [31:0] nw;
            chk("rnd_valid", 32'(a_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) chk("rnd_data", a_data, mq[0]);
            chk("rnd_level", 32'(a_lvl), mq.size());
            chk("rnd_cnt", 32'(a_cnt), part.size());
            chk("rnd_ovf", 32'(a_ovf), 32'(m_ovf));
            chk("rnd_ferr", 32'(a_ferr), 32'(m_ferr));

            if (cyc % 20 == 0) mode = $urandom_range(0, 3);
            case (mode)
                0: begin rx_done = ($urandom_range(0, 9) < 8); word_ready = ($urandom_range(0, 9) < 8); end
                1: begin rx_done = ($urandom_range(0, 9) < 8); word_ready = ($urandom_range(0, 9) < 1); end
                2: begin rx_done = ($urandom_range(0, 19) == 0); word_ready = ($urandom_range(0, 1) == 1); end
                default: begin rx_done = ($urandom_range(0, 1) == 1); word_ready = ($urandom_range(0, 1) == 1); end
            endcase
            rx_byte   = 8'($urandom);
            flush     = ($urandom_range(0, 79) == 0);
            clear_ovf = ($urandom_range(0, 15) == 0);

            full = (mq.size() == 4);
            pop  = (mq.size() != 0) && word_ready;
            done = 1'b0;
            drop = 1'b0;
            nw   = '0;
            if (flush) begin
                mq.delete(); part.delete(); m_idle = 0; m_ovf = 1'b0; m_ferr = 1'b0;
            end else begin
                m_ferr = 1'b0;
                if (rx_done) begin
                    part.push_back(rx_byte);
                    m_idle = 0;
                    if (part.size() == 4) begin
                        nw = {part[3], part[2], part[1], part[0]};
                        part.delete();
                        done = 1'b1;
                    end
                end else if (part.size() != 0) begin
                    m_idle++;
                    if (m_idle == 10) begin
                        part.delete();
                        m_idle = 0;
                        m_ferr = 1'b1;
                    end
                end else begin
                    m_idle = 0;
                end
                if (pop) void'(mq.pop_front());
                if (done) begin
                    if (full && !pop) drop = 1'b1;
                    else mq.push_back(nw);
                end
                if (drop) m_ovf = 1'b1;
                else if (clear_ovf) m_ovf = 1'b0;
            end
            @(negedge clk);
        end
        rx_done = 1'b0; flush = 1'b0; clear_ovf = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_word_assembler
